gemm_row_collector: RTL

//  Output stage directly downstream of the DA GEMM array. Captures each completed output row
//  (N signed results, one row per DATA_WIDTH_A-cycle DA pass), requantizes (rounded arithmetic

---
 rtl/gemm_row_collector.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gemm_row_collector.sv
// Output stage behind the DA GEMM array: requantizes each completed row, tags it with its
// row index, and streams it out of a small first-word-fall-through FIFO over valid/ready.
module gemm_row_collector #(
    parameter int N          = 4,
    parameter int M          = 2,
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT_W    = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (M > 1) ? $clog2(M) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   row_valid,
    input  logic [N*IN_WIDTH-1:0]  row_data,
    input  logic [SHIFT_W-1:0]     shift,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*OUT_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]       out_row_idx,
    output logic                   out_last,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   overflow_err
);
    localparam logic        [IN_WIDTH:0] ONE     = (IN_WIDTH+1)'(1);
    localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((2 ** (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic [N*OUT_WIDTH-1:0] quant_row;

    // Per-column requantization; one guard bit keeps the rounding add from overflowing.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_col
            logic signed [IN_WIDTH:0]    ext_val;
            logic signed [IN_WIDTH:0]    rnd_val;
            logic signed [IN_WIDTH:0]    sum_val;
            logic signed [IN_WIDTH:0]    shr_val;
            logic signed [IN_WIDTH:0]    relu_val;
            logic        [OUT_WIDTH-1:0] sat_val;

            always_comb begin
                ext_val  = signed'({row_data[gi*IN_WIDTH + IN_WIDTH - 1],
                                    row_data[gi*IN_WIDTH +: IN_WIDTH]});
                rnd_val  = '0;
                if (shift != '0) begin
                    rnd_val = signed'(ONE << (shift - SHIFT_W'(1)));
                end
                sum_val  = ext_val + rnd_val;
                shr_val  = sum_val >>> shift;
                relu_val = (relu_en && shr_val < 0) ? '0 : shr_val;
                if (relu_val > SAT_MAX) begin
                    sat_val = SAT_MAX[OUT_WIDTH-1:0];
                end else if (relu_val < SAT_MIN) begin
                    sat_val = SAT_MIN[OUT_WIDTH-1:0];
                end else begin
                    sat_val = relu_val[OUT_WIDTH-1:0];
                end
            end

            assign quant_row[gi*OUT_WIDTH +: OUT_WIDTH] = sat_val;
        end
    endgenerate

    logic                   s1_valid_reg;
    logic [N*OUT_WIDTH-1:0] s1_data_reg;
    logic [IDX_W-1:0]       s1_idx_reg;
    logic [IDX_W-1:0]       row_idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_idx_reg   <= '0;
            row_idx_reg  <= '0;
        end else if (clear) begin
            s1_valid_reg <= 1'b0;
            row_idx_reg  <= '0;
        end else begin
            s1_valid_reg <= row_valid;
            if (row_valid) begin
                s1_data_reg <= quant_row;
                s1_idx_reg  <= row_idx_reg;
                row_idx_reg <= (row_idx_reg == IDX_W'(M-1)) ? '0 : row_idx_reg + IDX_W'(1);
            end
        end
    end

    logic [N*OUT_WIDTH-1:0] mem_data_reg [FIFO_DEPTH];
    logic [IDX_W-1:0]       mem_idx_reg  [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [CNT_W-1:0]       count_next;
    logic                   overflow_reg;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        pop  = (count_reg != '0) && out_ready;
        push = s1_valid_reg && ((count_reg != CNT_W'(FIFO_DEPTH)) || pop);
        drop = s1_valid_reg && !push;
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            if (drop) overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_reg[i] <= '0;
                mem_idx_reg[i]  <= '0;
            end
        end else if (push && !clear) begin
            mem_data_reg[wr_ptr_reg] <= s1_data_reg;
            mem_idx_reg[wr_ptr_reg]  <= s1_idx_reg;
        end
    end

    assign out_valid    = (count_reg != '0);
    assign out_data     = mem_data_reg[rd_ptr_reg];
    assign out_row_idx  = mem_idx_reg[rd_ptr_reg];
    assign out_last     = (out_row_idx == IDX_W'(M-1));
    assign fifo_count   = count_reg;
    assign overflow_err = overflow_reg;
endmodule
